// File: rtl/reset_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reset_seq_pkg: shared state encoding and sizing helpers for the reset     |
// | sequencer.                                                                |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_LOCK_WAIT = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3
  } seq_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sync_bit: multi-flop single-bit synchronizer with synchronous clear.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module sync_bit
  import reset_seq_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    if (clr) begin
      sync_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reset_sequencer: ordered release of N active-low reset domains after PLL  |
// | lock, with teardown on lock loss or accepted software reset.              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int LOCK_CYCLES = 1024,
  parameter int STEP_CYCLES = 16,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 soft_rst_valid,
  output logic                 soft_rst_ready,
  output logic                 soft_rst_done,
  output logic [N_DOMAINS-1:0] domain_resetn,
  output logic                 all_released,
  output logic [2:0]           seq_state
);

  localparam int CNT_W = $clog2(max3(LOCK_CYCLES, STEP_CYCLES, HOLD_CYCLES) + 1);
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 rel_q, rel_d;
  logic                 done_q, done_d;
  logic                 pend_q, pend_d;
  logic                 lock_s;
  logic                 enter_hold;

  // Synchronizer is flushed during HOLD so every release needs lock freshly
  // observed after the hold window, giving the same timing from any teardown.
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_HOLD),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dom_d      = dom_q;
    rel_d      = rel_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    enter_hold = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_LOCK_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOCK_WAIT: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          enter_hold = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            rel_d   = 1'b1;
            done_d  = pend_q;
            pend_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Lock loss wins; the request stays unconsumed and is retried later.
        if (!lock_s) begin
          enter_hold = 1'b1;
        end else if (soft_rst_valid) begin
          pend_d     = 1'b1;
          enter_hold = 1'b1;
        end
      end
      default: enter_hold = 1'b1;
    endcase

    if (enter_hold) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      rel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      rel_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign soft_rst_ready = (state_q == ST_RUN);
  assign soft_rst_done  = done_q;
  assign domain_resetn  = dom_q;
  assign all_released   = rel_q;
  assign seq_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_reset_sequencer: directed self-checking bench for reset_sequencer.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_reset_sequencer;

  localparam int N_DOMAINS   = 3;
  localparam int LOCK_CYCLES = 8;
  localparam int STEP_CYCLES = 4;
  localparam int HOLD_CYCLES = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pll_locked;
  logic                 soft_rst_valid;
  logic                 soft_rst_ready;
  logic                 soft_rst_done;
  logic [N_DOMAINS-1:0] domain_resetn;
  logic                 all_released;
  logic [2:0]           seq_state;

  int checks     = 0;
  int failures   = 0;
  int t          = 0;
  int done_count = 0;
  int done_base  = 0;

  reset_sequencer #(
    .N_DOMAINS   (N_DOMAINS),
    .LOCK_CYCLES (LOCK_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .soft_rst_valid (soft_rst_valid),
    .soft_rst_ready (soft_rst_ready),
    .soft_rst_done  (soft_rst_done),
    .domain_resetn  (domain_resetn),
    .all_released   (all_released),
    .seq_state      (seq_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (soft_rst_done === 1'b1) done_count <= done_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [2:0] dom, input logic rel,
                             input logic [2:0] st);
    check({tag, ".dom"}, 32'(domain_resetn), 32'(dom));
    check({tag, ".rel"}, 32'(all_released), 32'(rel));
    check({tag, ".st"},  32'(seq_state), 32'(st));
  endtask

  // Advance to the negedge following edge number target (target > t).
  task automatic step_to(input int target);
    while (t < target) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    t     = 0;
  endtask

  initial begin
    reset          = 1'b1;
    pll_locked     = 1'b1;
    soft_rst_valid = 1'b0;

    // Scenario 1: clean power-up sequence
    do_reset();
    expect_outs("rst", 3'b000, 1'b0, 3'd0);
    check("rst.done", 32'(soft_rst_done), 32'd0);
    check("rst.rdy",  32'(soft_rst_ready), 32'd0);
    step_to(5);  expect_outs("s1.lw", 3'b000, 1'b0, 3'd1);
    step_to(13); expect_outs("s1.lw_end", 3'b000, 1'b0, 3'd1);
    step_to(14); expect_outs("s1.rel_in", 3'b000, 1'b0, 3'd2);
    step_to(17); expect_outs("s1.t17", 3'b000, 1'b0, 3'd2);
    step_to(18); expect_outs("s1.t18", 3'b001, 1'b0, 3'd2);
    step_to(21); expect_outs("s1.t21", 3'b001, 1'b0, 3'd2);
    step_to(22); expect_outs("s1.t22", 3'b011, 1'b0, 3'd2);
    step_to(25); expect_outs("s1.t25", 3'b011, 1'b0, 3'd2);
    step_to(26); expect_outs("s1.t26", 3'b111, 1'b1, 3'd3);
    check("s1.done", 32'(soft_rst_done), 32'd0);

    // Scenario 3: accepted soft reset from RUN, then full resequence
    done_base = done_count;
    step_to(30);
    soft_rst_valid = 1'b1;
    check("s3.rdy", 32'(soft_rst_ready), 32'd1);
    step_to(31);
    soft_rst_valid = 1'b0;
    expect_outs("s3.torn", 3'b000, 1'b0, 3'd0);
    check("s3.rdy_lo", 32'(soft_rst_ready), 32'd0);
    step_to(48); expect_outs("s3.t48", 3'b000, 1'b0, 3'd2);
    step_to(49); expect_outs("s3.t49", 3'b001, 1'b0, 3'd2);
    step_to(53); expect_outs("s3.t53", 3'b011, 1'b0, 3'd2);
    step_to(56);
    check("s3.done_pre", 32'(soft_rst_done), 32'd0);
    step_to(57); expect_outs("s3.t57", 3'b111, 1'b1, 3'd3);
    check("s3.done", 32'(soft_rst_done), 32'd1);
    step_to(58);
    check("s3.done_post", 32'(soft_rst_done), 32'd0);
    check("s3.done_cnt", 32'(done_count - done_base), 32'd1);

    // Scenario 2: one-cycle lock glitch at LOCK_WAIT cnt=5
    do_reset();
    step_to(11);
    pll_locked = 1'b0;
    step_to(12);
    pll_locked = 1'b1;
    step_to(14); expect_outs("s2.t14", 3'b000, 1'b0, 3'd1);
    step_to(21); expect_outs("s2.t21", 3'b000, 1'b0, 3'd1);
    step_to(22); expect_outs("s2.t22", 3'b000, 1'b0, 3'd2);
    step_to(25); expect_outs("s2.t25", 3'b000, 1'b0, 3'd2);
    step_to(26); expect_outs("s2.t26", 3'b001, 1'b0, 3'd2);
    step_to(30); expect_outs("s2.t30", 3'b011, 1'b0, 3'd2);
    step_to(33); expect_outs("s2.t33", 3'b011, 1'b0, 3'd2);
    step_to(34); expect_outs("s2.t34", 3'b111, 1'b1, 3'd3);

    // Scenario 4: lock loss in RELEASE with two domains out
    do_reset();
    done_base = done_count;
    step_to(22);
    pll_locked = 1'b0;
    step_to(24); expect_outs("s4.t24", 3'b011, 1'b0, 3'd2);
    step_to(25); expect_outs("s4.t25", 3'b000, 1'b0, 3'd0);
    pll_locked = 1'b1;
    step_to(42); expect_outs("s4.t42", 3'b000, 1'b0, 3'd2);
    step_to(43); expect_outs("s4.t43", 3'b001, 1'b0, 3'd2);
    step_to(47); expect_outs("s4.t47", 3'b011, 1'b0, 3'd2);
    step_to(51); expect_outs("s4.t51", 3'b111, 1'b1, 3'd3);
    check("s4.done", 32'(soft_rst_done), 32'd0);
    step_to(52);
    check("s4.done_cnt", 32'(done_count - done_base), 32'd0);

    // Scenario 5: soft request coincident with lock loss in RUN
    done_base = done_count;
    step_to(55);
    pll_locked = 1'b0;
    step_to(57);
    soft_rst_valid = 1'b1;
    check("s5.rdy", 32'(soft_rst_ready), 32'd1);
    step_to(58); expect_outs("s5.t58", 3'b000, 1'b0, 3'd0);
    check("s5.rdy_lo", 32'(soft_rst_ready), 32'd0);
    pll_locked = 1'b1;
    step_to(83); expect_outs("s5.t83", 3'b011, 1'b0, 3'd2);
    step_to(84); expect_outs("s5.t84", 3'b111, 1'b1, 3'd3);
    check("s5.done84", 32'(soft_rst_done), 32'd0);
    check("s5.rdy84",  32'(soft_rst_ready), 32'd1);
    step_to(85); expect_outs("s5.t85", 3'b000, 1'b0, 3'd0);
    soft_rst_valid = 1'b0;
    step_to(110); expect_outs("s5.t110", 3'b011, 1'b0, 3'd2);
    step_to(111); expect_outs("s5.t111", 3'b111, 1'b1, 3'd3);
    check("s5.done111", 32'(soft_rst_done), 32'd1);
    step_to(112);
    check("s5.done_cnt", 32'(done_count - done_base), 32'd1);

    // Scenario 6: reset pulsed mid-RELEASE
    do_reset();
    step_to(20); expect_outs("s6.t20", 3'b001, 1'b0, 3'd2);
    reset = 1'b1;
    step_to(21); expect_outs("s6.rst", 3'b000, 1'b0, 3'd0);
    check("s6.rdy", 32'(soft_rst_ready), 32'd0);
    reset = 1'b0;
    t     = 0;
    step_to(17); expect_outs("s6.t17", 3'b000, 1'b0, 3'd2);
    step_to(18); expect_outs("s6.t18", 3'b001, 1'b0, 3'd2);
    step_to(22); expect_outs("s6.t22", 3'b011, 1'b0, 3'd2);
    step_to(26); expect_outs("s6.t26", 3'b111, 1'b1, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
